// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator: owns the fetch PC, combines BTB hit/target with
// 2-bit direction counters, redirects on execute mispredicts, and requests BTB writes.
module next_pc_predictor #(
    parameter int          W_IDX    = 4,
    parameter int          W_TAG    = 8,
    parameter int          W_CNT    = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [31:0]       pc,
    input  logic              btb_hit,
    input  logic [31:0]       btb_bta,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              flush,
    output logic              btb_wr_en,
    output logic [W_TAG-1:0]  btb_wr_pc,
    output logic [31:0]       btb_wr_bta,
    output logic [W_CNT-1:0]  stat_branches,
    output logic [W_CNT-1:0]  stat_mispredicts
);

    localparam int         N_ENT    = 1 << W_IDX;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic [1:0]       pht [N_ENT];
    logic [31:0]      pc_p0;
    logic [31:0]      pc_plus4;
    logic [31:0]      ex_pc_plus4;
    logic [31:0]      next_pc;
    logic [W_IDX-1:0] rd_idx;
    logic [W_IDX-1:0] wr_idx;
    logic             mispred;
    logic             target_miss;
    logic             btb_req;
    logic             wr_en_p1;
    logic [W_TAG-1:0] wr_pc_p1;
    logic [31:0]      wr_bta_p1;
    logic [W_CNT-1:0] br_cnt;
    logic [W_CNT-1:0] mp_cnt;

    // Two-bit saturating direction counter step.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [W_CNT-1:0] stat_inc(input logic [W_CNT-1:0] cnt, input logic en);
        logic [W_CNT-1:0] res;
        res = cnt;
        if (en && (cnt != {W_CNT{1'b1}})) res = cnt + {{(W_CNT-1){1'b0}}, 1'b1};
        return res;
    endfunction

    assign rd_idx      = pc_p0[W_IDX+1:2];
    assign wr_idx      = ex_pc[W_IDX+1:2];
    assign pc_plus4    = pc_p0 + 32'd4;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    // Stage p0: lookup of the current fetch PC; the mux keeps btb_bta out of the
    // result whenever the BTB misses, so an unknown target never reaches the outputs.
    assign pred_taken  = btb_hit & pht[rd_idx][1];
    assign pred_target = pred_taken ? btb_bta : pc_plus4;

    assign target_miss = ex_taken & ex_pred_taken & (ex_target != ex_pred_target);
    assign mispred     = ex_valid & ((ex_taken != ex_pred_taken) | target_miss);
    assign flush       = mispred;
    assign btb_req     = ex_valid & ex_taken & mispred;

    always_comb begin
        next_pc = pred_target;
        if (mispred) begin
            next_pc = ex_taken ? ex_target : ex_pc_plus4;
        end else if (stall) begin
            next_pc = pc_p0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0 <= RESET_PC;
        end else begin
            pc_p0 <= next_pc;
        end
    end

    // Table write lands at the edge; a same-cycle lookup sees the old counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENT; i++) pht[i] <= CTR_INIT;
        end else if (ex_valid) begin
            pht[wr_idx] <= ctr_next(pht[wr_idx], ex_taken);
        end
    end

    // Stage p1: one-cycle BTB write strobe; tag/target hold between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_p1  <= 1'b0;
            wr_pc_p1  <= '0;
            wr_bta_p1 <= '0;
        end else begin
            wr_en_p1 <= btb_req;
            if (btb_req) begin
                wr_pc_p1  <= ex_pc[W_TAG-1:0];
                wr_bta_p1 <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            br_cnt <= stat_inc(br_cnt, ex_valid);
            mp_cnt <= stat_inc(mp_cnt, mispred);
        end
    end

    assign pc               = pc_p0;
    assign btb_wr_en        = wr_en_p1;
    assign btb_wr_pc        = wr_pc_p1;
    assign btb_wr_bta       = wr_bta_p1;
    assign stat_branches    = br_cnt;
    assign stat_mispredicts = mp_cnt;

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed self-checking bench for next_pc_predictor (RESET_PC=0x100, W_CNT=4).
module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        btb_hit = 1'b0;
    logic [31:0] btb_bta = 32'h0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'h0;
    logic        flush;
    logic        btb_wr_en;
    logic [7:0]  btb_wr_pc;
    logic [31:0] btb_wr_bta;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    next_pc_predictor #(
        .W_IDX(4), .W_TAG(8), .W_CNT(4), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .btb_hit(btb_hit), .btb_bta(btb_bta),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_bta(btb_wr_bta),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] p, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid = v; ex_pc = p; ex_taken = t; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        tick(); tick();
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'h100); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", flush); end
        n_cmp++; if (btb_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", btb_wr_en); end
        n_cmp++; if (btb_wr_pc !== 8'h0 || btb_wr_bta !== 32'h0) begin n_err++; $display("FAIL reset_wr_fields got %h/%h want 0/0", btb_wr_pc, btb_wr_bta); end
        n_cmp++; if (stat_branches !== 4'h0 || stat_mispredicts !== 4'h0) begin n_err++; $display("FAIL reset_stats got %h/%h want 0/0", stat_branches, stat_mispredicts); end
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_err++; $display("FAIL reset_pred got %b/%h want 0/104", pred_taken, pred_target); end
        reset = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h104) begin n_err++; $display("FAIL seq_pc1 got %h want 104", pc); end
        tick();
        n_cmp++; if (pc !== 32'h108) begin n_err++; $display("FAIL seq_pc2 got %h want 108", pc); end
        tick();
        n_cmp++; if (pc !== 32'h10C) begin n_err++; $display("FAIL seq_pc3 got %h want 10C", pc); end
    endtask

    task automatic test_training();
        stall = 1'b1; btb_hit = 1'b1; btb_bta = 32'h200;
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h110) begin n_err++; $display("FAIL train_init got %b/%h want 0/110", pred_taken, pred_target); end
        set_ex(1'b1, 32'h10C, 1'b1, 32'h200, 1'b1, 32'h200);
        #1;
        n_cmp++; if (flush !== 1'b0 || pred_taken !== 1'b0) begin n_err++; $display("FAIL train_same_cycle got flush %b pred %b want 0/0", flush, pred_taken); end
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h200 || pc !== 32'h10C) begin n_err++; $display("FAIL train_taken got %b/%h pc %h want 1/200 pc 10C", pred_taken, pred_target, pc); end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL train_jump got %h want 200", pc); end
        btb_hit = 1'b0;
        set_ex(1'b1, 32'h10C, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h20C || stat_branches !== 4'd4) begin n_err++; $display("FAIL train_nt got pc %h br %0d want 20C 4", pc, stat_branches); end
        btb_hit = 1'b1; btb_bta = 32'h300; stall = 1'b1;
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h210) begin n_err++; $display("FAIL train_floor got %b/%h want 0/210", pred_taken, pred_target); end
        set_ex(1'b1, 32'h20C, 1'b1, 32'h300, 1'b1, 32'h300);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL train_no_underflow got %b want 0", pred_taken); end
        n_cmp++; if (stat_branches !== 4'd5 || stat_mispredicts !== 4'd0) begin n_err++; $display("FAIL train_stats got %0d/%0d want 5/0", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_mispredict();
        btb_hit = 1'b0;
        set_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL mp_flush got %b want 1", flush); end
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL mp_redirect got %h want 80", pc); end
        n_cmp++; if (btb_wr_en !== 1'b1 || btb_wr_pc !== 8'h40 || btb_wr_bta !== 32'h80) begin n_err++; $display("FAIL mp_btb_wr got %b/%h/%h want 1/40/80", btb_wr_en, btb_wr_pc, btb_wr_bta); end
        tick();
        n_cmp++; if (btb_wr_en !== 1'b0 || btb_wr_pc !== 8'h40 || pc !== 32'h80) begin n_err++; $display("FAIL mp_strobe_end got %b/%h pc %h want 0/40 pc 80", btb_wr_en, btb_wr_pc, pc); end
        n_cmp++; if (stat_branches !== 4'd6 || stat_mispredicts !== 4'd1) begin n_err++; $display("FAIL mp_stats got %0d/%0d want 6/1", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_target_mismatch();
        stall = 1'b0;
        set_ex(1'b1, 32'h50, 1'b1, 32'h94, 1'b1, 32'h90);
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL tm_flush got %b want 1", flush); end
        tick();
        n_cmp++; if (pc !== 32'h94 || btb_wr_en !== 1'b1 || btb_wr_pc !== 8'h50 || btb_wr_bta !== 32'h94) begin n_err++; $display("FAIL tm_redirect got pc %h wr %b/%h/%h want 94 1/50/94", pc, btb_wr_en, btb_wr_pc, btb_wr_bta); end
        set_ex(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL tm_correct_nt got %b want 0", flush); end
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (btb_wr_en !== 1'b0 || pc !== 32'h98 || btb_wr_bta !== 32'h94) begin n_err++; $display("FAIL tm_after got wr %b pc %h bta %h want 0 98 94", btb_wr_en, pc, btb_wr_bta); end
        n_cmp++; if (stat_branches !== 4'd8 || stat_mispredicts !== 4'd2) begin n_err++; $display("FAIL tm_stats got %0d/%0d want 8/2", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        set_ex(1'b1, 32'h60, 1'b1, 32'hA0, 1'b0, 32'h64);
        tick();
        n_cmp++; if (btb_wr_en !== 1'b1 || btb_wr_pc !== 8'h60 || pc !== 32'hA0) begin n_err++; $display("FAIL b2b_first got %b/%h pc %h want 1/60 pc A0", btb_wr_en, btb_wr_pc, pc); end
        set_ex(1'b1, 32'h70, 1'b1, 32'hB0, 1'b0, 32'h74);
        tick();
        n_cmp++; if (btb_wr_en !== 1'b1 || btb_wr_pc !== 8'h70 || btb_wr_bta !== 32'hB0 || pc !== 32'hB0) begin n_err++; $display("FAIL b2b_second got %b/%h/%h pc %h want 1/70/B0 pc B0", btb_wr_en, btb_wr_pc, btb_wr_bta, pc); end
        set_ex(1'b1, 32'hC0, 1'b0, 32'h0, 1'b1, 32'hC8);
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL b2b_nt_flush got %b want 1", flush); end
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        stall = 1'b0;
        n_cmp++; if (pc !== 32'hC4 || btb_wr_en !== 1'b0 || btb_wr_pc !== 8'h70) begin n_err++; $display("FAIL b2b_nt_redirect got pc %h wr %b/%h want C4 0/70", pc, btb_wr_en, btb_wr_pc); end
        n_cmp++; if (stat_branches !== 4'd11 || stat_mispredicts !== 4'd5) begin n_err++; $display("FAIL b2b_stats got %0d/%0d want 11/5", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_wrap();
        set_ex(1'b1, 32'h10, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h14);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        btb_hit = 1'b0; btb_bta = 'x;
        #1;
        n_cmp++; if (pc !== 32'hFFFFFFFC || pred_taken !== 1'b0 || pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_pred got pc %h %b/%h want FFFFFFFC 0/0", pc, pred_taken, pred_target); end
        tick();
        btb_bta = 32'h0;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", pc); end
    endtask

    task automatic test_saturation();
        set_ex(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h28);
        for (int i = 0; i < 20; i++) tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (stat_branches !== 4'hF || stat_mispredicts !== 4'hF) begin n_err++; $display("FAIL sat_stats got %h/%h want F/F", stat_branches, stat_mispredicts); end
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL sat_pc got %h want 24", pc); end
    endtask

    task automatic test_async_reset();
        set_ex(1'b1, 32'h30, 1'b1, 32'h300, 1'b0, 32'h34);
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++; if (btb_wr_en !== 1'b1) begin n_err++; $display("FAIL ar_strobe got %b want 1", btb_wr_en); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (btb_wr_en !== 1'b0 || pc !== 32'h100) begin n_err++; $display("FAIL ar_clear got wr %b pc %h want 0 100", btb_wr_en, pc); end
        n_cmp++; if (stat_branches !== 4'h0 || stat_mispredicts !== 4'h0 || btb_wr_pc !== 8'h0 || btb_wr_bta !== 32'h0) begin n_err++; $display("FAIL ar_state got %h/%h %h/%h want 0/0 0/0", stat_branches, stat_mispredicts, btb_wr_pc, btb_wr_bta); end
        #2 reset = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h104 || btb_wr_en !== 1'b0) begin n_err++; $display("FAIL ar_resume got pc %h wr %b want 104 0", pc, btb_wr_en); end
    endtask

    initial begin
        test_reset();
        test_training();
        test_mispredict();
        test_target_mismatch();
        test_back_to_back();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
